// File: rtl/pet2001_prg_loader.sv
// pet2001_prg_loader: host PRG/ROM byte stream to PET DMA writes with BASIC pointer patch, optional PRG_AUTORUN_EN keyboard-buffer RUN
module pet2001_prg_loader #(
  parameter logic [15:0] PTR_BASE = 16'h002A
`ifdef PRG_AUTORUN_EN
  ,
  parameter logic [15:0] KBUF_ADDR = 16'h026F,
  parameter logic [15:0] KBCNT_ADDR = 16'h009E
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dl_active,
  input  logic        dl_type,
  input  logic        dl_wr,
  input  logic [7:0]  dl_data,
  output logic        dl_ready,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_din,
  output logic        dma_we,
  output logic        busy,
  output logic        done,
  output logic        err
);
  typedef enum logic [2:0] {
    IDLE, HDR_LO, HDR_HI, DATA, WR, PATCH,
`ifdef PRG_AUTORUN_EN
    KBUF,
`endif
    DONE
  } state_t;
  state_t state_q, state_d, ret_q, ret_d;
  logic rom_q, rom_d, act_q, has_data_q, has_data_d, err_q, err_d, wr_ok_q, wr_ok_d;
  logic [15:0] cursor_q, cursor_d, addr_q, addr_d, end_addr;
  logic [7:0] din_q, din_d;
  logic [2:0] idx_q, idx_d;
  logic rise;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      rom_q      <= 1'b0;
      act_q      <= 1'b0;
      has_data_q <= 1'b0;
      err_q      <= 1'b0;
      wr_ok_q    <= 1'b0;
      cursor_q   <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      rom_q      <= rom_d;
      act_q      <= dl_active;
      has_data_q <= has_data_d;
      err_q      <= err_d;
      wr_ok_q    <= wr_ok_d;
      cursor_q   <= cursor_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      idx_q      <= idx_d;
    end
  end
  assign rise = dl_active & ~act_q;
  assign end_addr = cursor_q[15] ? 16'h8000 : cursor_q;
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    rom_d      = rom_q;
    has_data_d = has_data_q;
    err_d      = err_q;
    wr_ok_d    = wr_ok_q;
    cursor_d   = cursor_q;
    addr_d     = addr_q;
    din_d      = din_q;
    idx_d      = idx_q;
    case (state_q)
      IDLE, DONE: if (rise) begin
        state_d    = dl_type ? DATA : HDR_LO;
        rom_d      = dl_type;
        err_d      = 1'b0;
        cursor_d   = '0;
        has_data_d = 1'b0;
        idx_d      = '0;
      end
      HDR_LO: if (!dl_active) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else if (dl_wr) begin
        cursor_d[7:0] = dl_data;
        state_d       = HDR_HI;
      end
      HDR_HI: if (!dl_active) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else if (dl_wr) begin
        cursor_d[15:8] = dl_data;
        state_d        = DATA;
      end
      DATA: if (!dl_active) begin
        state_d = (rom_q || !has_data_q) ? DONE : PATCH;
      end else if (dl_wr) begin
        has_data_d = 1'b1;
        addr_d     = rom_q ? {1'b1, cursor_q[14:0]} : cursor_q;
        din_d      = dl_data;
        wr_ok_d    = ~cursor_q[15];
        err_d      = err_q | cursor_q[15];
        ret_d      = DATA;
        state_d    = WR;
      end
      WR: begin
        state_d = ret_q;
        if (ret_q == DATA && !cursor_q[15]) cursor_d = cursor_q + 16'd1;
      end
      PATCH: if (idx_q == 3'd6) begin
        idx_d = '0;
`ifdef PRG_AUTORUN_EN
        state_d = KBUF;
`else
        state_d = DONE;
`endif
      end else begin
        addr_d  = PTR_BASE + {13'd0, idx_q};
        din_d   = idx_q[0] ? end_addr[15:8] : end_addr[7:0];
        wr_ok_d = 1'b1;
        ret_d   = PATCH;
        state_d = WR;
        idx_d   = idx_q + 3'd1;
      end
`ifdef PRG_AUTORUN_EN
      KBUF: if (idx_q == 3'd5) begin
        state_d = DONE;
      end else begin
        addr_d  = (idx_q == 3'd4) ? KBCNT_ADDR : KBUF_ADDR + {13'd0, idx_q};
        din_d   = (idx_q == 3'd0) ? 8'h52 : (idx_q == 3'd1) ? 8'h55 :
                  (idx_q == 3'd2) ? 8'h4E : (idx_q == 3'd3) ? 8'h0D : 8'h04;
        wr_ok_d = 1'b1;
        ret_d   = KBUF;
        state_d = WR;
        idx_d   = idx_q + 3'd1;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    dl_ready = state_q == HDR_LO || state_q == HDR_HI || state_q == DATA;
    dma_we   = state_q == WR && wr_ok_q;
    dma_addr = addr_q;
    dma_din  = din_q;
    busy     = !(state_q == IDLE || state_q == DONE);
    done     = state_q == DONE;
    err      = err_q;
  end
endmodule
